// File: rtl/switch_cleanup_pkg.sv
// Shared definitions for the switch-cleanup path: FSM state encoding and
// slow-counter wrap constants.
package switch_cleanup_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } sw_state_e;

    localparam logic [1:0] CNT_WRAP_FROM = 2'b11;
    localparam logic [1:0] CNT_WRAP_TO   = 2'b00;

    function automatic logic is_wrap(input logic [1:0] prev, input logic [1:0] cur);
        return (prev == CNT_WRAP_FROM) && (cur == CNT_WRAP_TO);
    endfunction

endpackage

// File: rtl/sw_sync_chain.sv
// Multi-flop synchroniser for the asynchronous raw switch level.
module sw_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/switch_debounce_fsm.sv
// Switch debouncer driven by slow-counter wrap strobes.
// Optional edge pulse outputs are built when SWITCH_EDGE_OUT_EN is defined.
module switch_debounce_fsm
    import switch_cleanup_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cnt_in,
    input  logic       sw_raw,
    output logic       clean_out,
    output logic       sample_stb,
    output logic       rise_pls,
    output logic       fall_pls
);

    localparam logic [3:0] STABLE_TGT = 4'(STABLE_SAMPLES);

    sw_state_e  state;
    logic [1:0] cnt_prev;
    logic [3:0] stable_cnt;
    logic       clean_q;
    logic       sw_sync;
    logic       stb;
    logic       disagree;
    logic       at_target;

    sw_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sw_raw),
        .dout (sw_sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_prev <= 2'b00;
        end else begin
            cnt_prev <= cnt_in;
        end
    end

    assign stb       = is_wrap(cnt_prev, cnt_in);
    // stable_cnt is 0 in both idle states, so one compare covers idle and wait
    assign disagree  = (sw_sync != clean_q);
    assign at_target = ((stable_cnt + 4'd1) == STABLE_TGT);

`ifdef SWITCH_EDGE_OUT_EN
    logic rise_q;
    logic fall_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE_LOW;
            clean_q    <= 1'b0;
            stable_cnt <= 4'd0;
`ifdef SWITCH_EDGE_OUT_EN
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
`endif
        end else begin
`ifdef SWITCH_EDGE_OUT_EN
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`endif
            case (state)
                IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW: begin
                    if (stb) begin
                        if (!disagree) begin
                            stable_cnt <= 4'd0;
                            state      <= clean_q ? IDLE_HIGH : IDLE_LOW;
                        end else if (at_target) begin
                            clean_q    <= ~clean_q;
                            stable_cnt <= 4'd0;
                            state      <= clean_q ? IDLE_LOW : IDLE_HIGH;
`ifdef SWITCH_EDGE_OUT_EN
                            rise_q     <= ~clean_q;
                            fall_q     <= clean_q;
`endif
                        end else begin
                            stable_cnt <= stable_cnt + 4'd1;
                            state      <= clean_q ? WAIT_LOW : WAIT_HIGH;
                        end
                    end
                end
                default: begin
                    state      <= IDLE_LOW;
                    clean_q    <= 1'b0;
                    stable_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign clean_out  = clean_q;
    assign sample_stb = stb;

`ifdef SWITCH_EDGE_OUT_EN
    assign rise_pls = rise_q;
    assign fall_pls = fall_q;
`else
    assign rise_pls = 1'b0;
    assign fall_pls = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_fsm.sv
// Self-checking bench for switch_debounce_fsm: directed scenarios plus a
// randomized run against a run-length reference model. Honours SWITCH_EDGE_OUT_EN.
module tb_switch_debounce_fsm;

    localparam int N = 4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] cnt_in = 2'b00;
    logic       sw_raw = 1'b0;
    logic       clean_out, sample_stb, rise_pls, fall_pls;

    switch_debounce_fsm #(
        .STABLE_SAMPLES (N),
        .SYNC_STAGES    (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .sw_raw     (sw_raw),
        .clean_out  (clean_out),
        .sample_stb (sample_stb),
        .rise_pls   (rise_pls),
        .fall_pls   (fall_pls)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: clean level, length of the current disagreeing strobe run,
    // last counter value seen, raw-switch history and expected pulses.
    logic       m_clean;
    int         m_run;
    logic [1:0] m_prev;
    logic       m_rise, m_fall;
    logic       hist[$];
    logic [1:0] ctr = 2'b00;
    int         stb_seen = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clean = 1'b0;
        m_run   = 0;
        m_prev  = 2'b00;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_front(1'b0);
    endtask

    task automatic step(input logic [1:0] c, input logic s, input logic r);
        logic exp_stb;
        logic samp;
        @(negedge clk);
        cnt_in = c;
        sw_raw = s;
        rst    = r;
        if (!r) model_reset();
        #1;
        exp_stb = r && (m_prev == 2'b11) && (c == 2'b00);
        check("sample_stb", sample_stb, exp_stb);
        if (exp_stb) stb_seen++;
        @(posedge clk);
        if (r) begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (exp_stb) begin
                samp = hist[S-1];
                if (samp != m_clean) begin
                    m_run++;
                    if (m_run == N) begin
                        m_clean = ~m_clean;
                        m_run   = 0;
                        if (m_clean) m_rise = 1'b1;
                        else         m_fall = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
            end
            hist.push_front(s);
            void'(hist.pop_back());
            m_prev = c;
        end
        #1;
        check("clean_out", clean_out, m_clean);
`ifdef SWITCH_EDGE_OUT_EN
        check("rise_pls", rise_pls, m_rise);
        check("fall_pls", fall_pls, m_fall);
`else
        check("rise_pls", rise_pls, 1'b0);
        check("fall_pls", fall_pls, 1'b0);
`endif
    endtask

    task automatic tick(input logic s);
        ctr = ctr + 2'd1;
        step(ctr, s, 1'b1);
    endtask

    // Free-running counter until n strobes have been consumed, bounded.
    task automatic run_strobes(input int n, input logic s);
        int start;
        int cyc;
        start = stb_seen;
        cyc   = 0;
        while ((stb_seen - start) < n && cyc < 16 * n + 16) begin
            tick(s);
            cyc++;
        end
        if ((stb_seen - start) < n) begin
            checks++;
            errors++;
            $error("FAIL strobe_timeout: observed %0d strobes expected %0d", stb_seen - start, n);
        end
    endtask

    initial begin
        logic held;
        int   hold;
        int   cyc;
        model_reset();

        // 1: reset held with switch high and counter running, then release
        for (int i = 0; i < 3; i++) begin
            ctr = ctr + 2'd1;
            step(ctr, 1'b1, 1'b0);
        end
        for (int i = 0; i < 24; i++) tick(1'b1);
        check("t1_clean_high", clean_out, 1'b1);

        // 2: full toggle with held levels
        for (int i = 0; i < 40; i++) tick(1'b0);
        check("t2_clean_low", clean_out, 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b1);
        check("t2_clean_high", clean_out, 1'b1);

        // 3: bounce pattern must restart the stable run
        run_strobes(8, 1'b0);
        check("t3_settled_low", clean_out, 1'b0);
        run_strobes(2, 1'b1);
        run_strobes(1, 1'b0);
        run_strobes(3, 1'b1);
        check("t3_no_flip_yet", clean_out, 1'b0);
        run_strobes(1, 1'b1);
        check("t3_flip", clean_out, 1'b1);

        // 4: stuck counter, no strobes whatever the switch does
        held = clean_out;
        for (int i = 0; i < 20; i++) step(2'b01, logic'($urandom_range(0, 1)), 1'b1);
        check("t4_clean_held", clean_out, held);
        ctr = 2'b01;

        // 5: async reset in the middle of a wait run
        run_strobes(8, 1'b0);
        cyc = 0;
        while (!(m_run == 3 && !m_clean) && cyc < 200) begin
            tick(1'b1);
            cyc++;
        end
        check("t5_reached_wait3", logic'(m_run == 3), 1'b1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("t5_rst_clean", clean_out, 1'b0);
        check("t5_rst_rise", rise_pls, 1'b0);
        check("t5_rst_stb", sample_stb, 1'b0);
        for (int i = 0; i < 2; i++) begin
            ctr = ctr + 2'd1;
            step(ctr, 1'b1, 1'b0);
        end
        for (int i = 0; i < 24; i++) tick(1'b1);
        check("t5_restart_high", clean_out, 1'b1);

        // 6: randomized counter behaviour, switch bouncing, rare resets
        held = 1'b0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                held = logic'($urandom_range(0, 1));
                hold = $urandom_range(1, 40);
            end
            hold--;
            case ($urandom_range(0, 19))
                0, 1:    ctr = ctr;
                2:       ctr = 2'($urandom_range(0, 3));
                default: ctr = ctr + 2'd1;
            endcase
            step(ctr, held, logic'($urandom_range(0, 499) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
